// File: rtl/nios_fprint_debug_pkg.sv
// Shared definitions for the cross-core debug halt sequencer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: FSM state encoding, lowest-set-bit one-hot helper, counter width helper.
package nios_fprint_debug_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HALTING  = 2'd1;
  localparam logic [1:0] ST_HALTED   = 2'd2;
  localparam logic [1:0] ST_RESUMING = 2'd3;

  // Widest supported cluster; the one-hot helper works at this width and
  // callers zero-extend / truncate to their own core count.
  localparam int MAX_CORES = 16;

  // Isolates the lowest set bit: v & -v. Lowest index wins ties.
  function automatic logic [MAX_CORES-1:0] lowest_onehot(input logic [MAX_CORES-1:0] v);
    return v & (~v + MAX_CORES'(1));
  endfunction

  // One extra bit over $clog2 so the terminal count is always reachable
  // and the counter can park above it without wrapping.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/nios_fprint_debug_timeout_ctr.sv
// Saturating cycle counter with synchronous clear, used as the state timeout.
// Latency: count updates one cycle after inc/clr; expired decodes the registered count.
// Backpressure: none; saturates at all-ones instead of wrapping.
// Ports: clk, reset_n (async active-low), clr, inc in; expired out (count == LIMIT-1).
module nios_fprint_debug_timeout_ctr
  import nios_fprint_debug_pkg::*;
#(
  parameter int LIMIT = 1024,
  parameter int W     = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/nios_fprint_debug_halt_sequencer.sv
// Cross-core debug halt coordinator: first enabled core entering debug pulls the rest in.
// Latency: all outputs registered; debugreq valid the edge after the triggering ack edge.
// Backpressure: none; stalls are bounded by TIMEOUT_CYCLES in HALTING and RESUMING.
// Ports: clk, reset_n, enable, core_mask, debugack, resume_req, clear_err in;
//        debugreq, halt_origin, halted_all, timeout_err, busy, state out.
module nios_fprint_debug_halt_sequencer
  import nios_fprint_debug_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [NUM_CORES-1:0] debugack,
  input  logic                 resume_req,
  input  logic                 clear_err,
  output logic [NUM_CORES-1:0] debugreq,
  output logic [NUM_CORES-1:0] halt_origin,
  output logic                 halted_all,
  output logic                 timeout_err,
  output logic                 busy,
  output logic [1:0]           state
);

  logic [NUM_CORES-1:0] ack_q;
  logic [NUM_CORES-1:0] mask_q;
  logic [NUM_CORES-1:0] rise;
  logic [NUM_CORES-1:0] origin_nxt;
  logic [MAX_CORES-1:0] rise_w;
  logic [MAX_CORES-1:0] origin_w;
  logic                 armed;
  logic                 expired;

  logic [1:0]           state_nxt;
  logic [NUM_CORES-1:0] req_nxt;
  logic                 halted_nxt;
  logic                 err_set;
  logic                 cnt_clr;
  logic                 cnt_inc;
  logic                 trigger;

  // ack_q is zero out of reset, so an ack already held high would look like
  // a fresh edge on the first clock. armed holds off triggering for that one
  // cycle so only a genuine fall-then-rise starts a sequence after reset.
  assign rise = {NUM_CORES{enable & ~busy & armed}} & debugack & ~ack_q & core_mask;

  assign rise_w     = MAX_CORES'(rise);
  assign origin_w   = lowest_onehot(rise_w);
  assign origin_nxt = NUM_CORES'(origin_w);

  assign cnt_inc = (state == ST_HALTING) || (state == ST_RESUMING);

  nios_fprint_debug_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .expired (expired)
  );

  always_comb begin
    state_nxt  = state;
    req_nxt    = debugreq;
    halted_nxt = halted_all;
    err_set    = 1'b0;
    cnt_clr    = 1'b0;
    trigger    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_nxt = '0;
        if (|rise) begin
          trigger   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_HALTING;
          // Request goes out on the same edge that captures the origin.
          req_nxt   = core_mask & ~origin_nxt;
        end
      end
      ST_HALTING: begin
        req_nxt = mask_q & ~halt_origin;
        // Completion is checked before the timeout so a last-cycle ack still counts.
        if ((debugack & mask_q) == mask_q) begin
          state_nxt  = ST_HALTED;
          req_nxt    = '0;
          halted_nxt = 1'b1;
        end else if (expired) begin
          err_set    = 1'b1;
          state_nxt  = ST_HALTED;
          req_nxt    = '0;
          halted_nxt = 1'b0;
        end
      end
      ST_HALTED: begin
        req_nxt = '0;
        if (resume_req) begin
          cnt_clr    = 1'b1;
          halted_nxt = 1'b0;
          state_nxt  = ST_RESUMING;
        end
      end
      ST_RESUMING: begin
        req_nxt = '0;
        if ((debugack & mask_q) == '0) begin
          state_nxt = ST_IDLE;
        end else if (expired) begin
          err_set   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      debugreq    <= '0;
      halt_origin <= '0;
      halted_all  <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      ack_q       <= '0;
      mask_q      <= '0;
      armed       <= 1'b0;
    end else begin
      state      <= state_nxt;
      debugreq   <= req_nxt;
      halted_all <= halted_nxt;
      busy       <= (state_nxt != ST_IDLE);
      ack_q      <= debugack;
      armed      <= 1'b1;
      if (trigger) begin
        halt_origin <= origin_nxt;
        mask_q      <= core_mask;
      end
      // A timeout landing with a clear keeps the flag set.
      if (err_set) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios_fprint_debug_halt_sequencer.sv
module tb_nios_fprint_debug_halt_sequencer;

  localparam int N = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HALTING = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [1:0] S_RESUMING = 2'd3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b1;
  logic [N-1:0] core_mask = 4'b1111;
  logic [N-1:0] debugack = '0;
  logic         resume_req = 1'b0;
  logic         clear_err = 1'b0;
  logic [N-1:0] debugreq;
  logic [N-1:0] halt_origin;
  logic         halted_all;
  logic         timeout_err;
  logic         busy;
  logic [1:0]   state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [3:0] req;
    logic [3:0] org;
    logic       hall;
    logic       err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  nios_fprint_debug_halt_sequencer #(
    .NUM_CORES      (N),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .core_mask   (core_mask),
    .debugack    (debugack),
    .resume_req  (resume_req),
    .clear_err   (clear_err),
    .debugreq    (debugreq),
    .halt_origin (halt_origin),
    .halted_all  (halted_all),
    .timeout_err (timeout_err),
    .busy        (busy),
    .state       (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus (called just after a negedge), queue the
  // outputs expected after the next rising edge, then pop and compare them.
  task automatic cyc(input logic [3:0] ack, input logic rr, input logic ce,
                     input logic [1:0] es, input logic [3:0] er, input logic [3:0] eo,
                     input logic eh, input logic ee, input string tag);
    exp_t e;
    debugack   = ack;
    resume_req = rr;
    clear_err  = ce;
    sb.push_back('{tag: tag, st: es, req: er, org: eo, hall: eh, err: ee});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".state"}, 32'(state), 32'(e.st));
      chk({e.tag, ".debugreq"}, 32'(debugreq), 32'(e.req));
      chk({e.tag, ".origin"}, 32'(halt_origin), 32'(e.org));
      chk({e.tag, ".halted_all"}, 32'(halted_all), 32'(e.hall));
      chk({e.tag, ".timeout_err"}, 32'(timeout_err), 32'(e.err));
      chk({e.tag, ".busy"}, 32'(busy), 32'(e.st != S_IDLE));
    end
    @(negedge clk);
    resume_req = 1'b0;
    clear_err  = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 32'(state), 32'(S_IDLE));
    chk("rst.debugreq", 32'(debugreq), 32'd0);
    chk("rst.origin", 32'(halt_origin), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(4'b0000, 0, 0, S_IDLE, 4'b0000, 4'b0000, 0, 0, "idle0");

    // Basic halt/resume
    cyc(4'b0100, 0, 0, S_HALTING,  4'b1011, 4'b0100, 0, 0, "basic_trig");
    cyc(4'b1111, 0, 0, S_HALTED,   4'b0000, 4'b0100, 1, 0, "basic_done");
    cyc(4'b1111, 0, 0, S_HALTED,   4'b0000, 4'b0100, 1, 0, "basic_hold");
    cyc(4'b1111, 1, 0, S_RESUMING, 4'b0000, 4'b0100, 0, 0, "basic_resume");
    cyc(4'b0000, 0, 0, S_IDLE,     4'b0000, 4'b0100, 0, 0, "basic_idle");
    cyc(4'b0000, 1, 0, S_IDLE,     4'b0000, 4'b0100, 0, 0, "resume_ignored");

    // Simultaneous rise: lowest index wins
    cyc(4'b1010, 0, 0, S_HALTING,  4'b1101, 4'b0010, 0, 0, "simul_trig");
    cyc(4'b1111, 0, 0, S_HALTED,   4'b0000, 4'b0010, 1, 0, "simul_done");
    cyc(4'b1111, 1, 0, S_RESUMING, 4'b0000, 4'b0010, 0, 0, "simul_resume");
    cyc(4'b0000, 0, 0, S_IDLE,     4'b0000, 4'b0010, 0, 0, "simul_idle");

    // Halt timeout: core 3 never acknowledges, 8 cycles in HALTING
    cyc(4'b0001, 0, 0, S_HALTING, 4'b1110, 4'b0001, 0, 0, "to_trig");
    for (int i = 0; i < 7; i++)
      cyc(4'b0111, 0, 0, S_HALTING, 4'b1110, 4'b0001, 0, 0, "to_wait");
    cyc(4'b0111, 0, 0, S_HALTED,   4'b0000, 4'b0001, 0, 1, "to_expire");
    cyc(4'b0111, 0, 1, S_HALTED,   4'b0000, 4'b0001, 0, 0, "to_clear");
    // Resume timeout with clear_err on the expiring cycle: set wins
    cyc(4'b0111, 1, 0, S_RESUMING, 4'b0000, 4'b0001, 0, 0, "rto_resume");
    for (int i = 0; i < 7; i++)
      cyc(4'b0111, 0, 0, S_RESUMING, 4'b0000, 4'b0001, 0, 0, "rto_wait");
    cyc(4'b0111, 0, 1, S_IDLE,     4'b0000, 4'b0001, 0, 1, "set_beats_clr");
    cyc(4'b0111, 0, 1, S_IDLE,     4'b0000, 4'b0001, 0, 0, "clr_after");
    cyc(4'b0000, 0, 0, S_IDLE,     4'b0000, 4'b0001, 0, 0, "to_idle");

    // Masking
    core_mask = 4'b0011;
    cyc(4'b1000, 0, 0, S_IDLE,    4'b0000, 4'b0001, 0, 0, "mask_block");
    cyc(4'b1001, 0, 0, S_HALTING, 4'b0010, 4'b0001, 0, 0, "mask_trig");
    core_mask = 4'b1111;
    cyc(4'b1001, 0, 0, S_HALTING,  4'b0010, 4'b0001, 0, 0, "mask_frozen");
    cyc(4'b1011, 0, 0, S_HALTED,   4'b0000, 4'b0001, 1, 0, "mask_done");
    cyc(4'b1011, 1, 0, S_RESUMING, 4'b0000, 4'b0001, 0, 0, "mask_resume");
    cyc(4'b1000, 0, 0, S_IDLE,     4'b0000, 4'b0001, 0, 0, "mask_idle");
    cyc(4'b0000, 0, 0, S_IDLE,     4'b0000, 4'b0001, 0, 0, "mask_quiet");

    // Single-core mask: no requests, done after one cycle
    core_mask = 4'b0100;
    cyc(4'b0100, 0, 0, S_HALTING,  4'b0000, 4'b0100, 0, 0, "one_trig");
    cyc(4'b0100, 0, 0, S_HALTED,   4'b0000, 4'b0100, 1, 0, "one_done");
    cyc(4'b0100, 1, 0, S_RESUMING, 4'b0000, 4'b0100, 0, 0, "one_resume");
    cyc(4'b0000, 0, 0, S_IDLE,     4'b0000, 4'b0100, 0, 0, "one_idle");
    core_mask = 4'b1111;

    // Enable gating and level-held ack
    enable = 1'b0;
    cyc(4'b0001, 0, 0, S_IDLE, 4'b0000, 4'b0100, 0, 0, "en_off");
    enable = 1'b1;
    cyc(4'b0001, 0, 0, S_IDLE, 4'b0000, 4'b0100, 0, 0, "level_no_trig");
    cyc(4'b0000, 0, 0, S_IDLE, 4'b0000, 4'b0100, 0, 0, "en_quiet");

    // Asynchronous reset mid-HALTING
    cyc(4'b0010, 0, 0, S_HALTING, 4'b1101, 4'b0010, 0, 0, "rst_trig");
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.debugreq", 32'(debugreq), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.state", 32'(state), 32'(S_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    cyc(4'b0010, 0, 0, S_IDLE,    4'b0000, 4'b0000, 0, 0, "arst_held1");
    cyc(4'b0010, 0, 0, S_IDLE,    4'b0000, 4'b0000, 0, 0, "arst_held2");
    cyc(4'b0000, 0, 0, S_IDLE,    4'b0000, 4'b0000, 0, 0, "arst_fall");
    cyc(4'b0010, 0, 0, S_HALTING, 4'b1101, 4'b0010, 0, 0, "arst_retrig");
    cyc(4'b1111, 0, 0, S_HALTED,  4'b0000, 4'b0010, 1, 0, "arst_done");

    chk("sb.drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
